// File: rtl/gpr_mp.sv
// gpr_mp: multi-port register file with write bypass, busy scoreboard and post-reset clear.
module gpr_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic                       set_en_i,
    input  logic [ADDR_W-1:0]          set_addr_i,
    output logic                       ready_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {INIT, RUN} state_t;
    state_t state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign wa[k] = wr_addr_i[k*ADDR_W +: ADDR_W];
        assign wd[k] = wr_data_i[k*DATA_W +: DATA_W];
    end
    // Set is applied after the clears so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NUM_WR; k++)
            if (wr_en_i[k]) busy_nxt[wa[k]] = 1'b0;
        if (set_en_i) busy_nxt[set_addr_i] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            busy    <= '0;
            ready_o <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1)) begin
                state   <= RUN;
                ready_o <= 1'b1;
            end
        end else begin
            busy <= busy_nxt;
        end
    end
    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (state == INIT)
            regs[cnt] <= '0;
        else
            for (int k = 0; k < NUM_WR; k++)
                if (wr_en_i[k] && !(ZERO_REG != 0 && wa[k] == '0))
                    regs[wa[k]] <= wd[k];
    end
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              hit;
        assign a = rd_addr_i[j*ADDR_W +: ADDR_W];
        always_comb begin
            d   = regs[a];
            hit = 1'b0;
            for (int k = 0; k < NUM_WR; k++)
                if (wr_en_i[k] && wa[k] == a) begin
                    d   = wd[k];
                    hit = 1'b1;
                end
        end
        assign rd_data_o[j*DATA_W +: DATA_W] = (!ready_o || (ZERO_REG != 0 && a == '0)) ? '0 : d;
        assign rd_busy_o[j] = ready_o && busy[a] && !hit;
    end
endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: randomized and directed checks of gpr_mp against an array-based reference model.
module tb_gpr_mp;
    localparam int DW = 32, AW = 5, NR = 2, NW = 2, D = 32;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [NW-1:0]    wr_en;
    logic [AW-1:0]    wa [NW];
    logic [DW-1:0]    wd [NW];
    logic [AW-1:0]    ra [NR];
    logic             set_en;
    logic [AW-1:0]    set_addr;
    logic [NW*AW-1:0] wr_addr_p;
    logic [NW*DW-1:0] wr_data_p;
    logic [NR*AW-1:0] rd_addr_p;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             ready;
    always_comb begin
        for (int k = 0; k < NW; k++) begin
            wr_addr_p[k*AW +: AW] = wa[k];
            wr_data_p[k*DW +: DW] = wd[k];
        end
        for (int j = 0; j < NR; j++) rd_addr_p[j*AW +: AW] = ra[j];
    end
    gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr_p), .wr_data_i(wr_data_p),
        .rd_addr_i(rd_addr_p), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .set_en_i(set_en), .set_addr_i(set_addr), .ready_o(ready)
    );
    int vectors = 0, miscompares = 0;
    logic [DW-1:0] m_regs [D];
    logic [D-1:0]  m_busy;
    int            edges;
    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic idle();
        wr_en  = '0;
        set_en = 1'b0;
    endtask
    // Called at a negedge with inputs already driven; checks outputs, then advances the model by one edge.
    task automatic cycle();
        logic [DW-1:0] e;
        logic hit, eb;
        #2;
        for (int j = 0; j < NR; j++) begin
            e   = m_regs[ra[j]];
            hit = 1'b0;
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && wa[k] == ra[j]) begin
                    e   = wd[k];
                    hit = 1'b1;
                end
            if (edges < D || ra[j] == 0) e = '0;
            eb = (edges >= D) && m_busy[ra[j]] && !hit;
            chk($sformatf("rd%0d_data", j), rd_data[j*DW +: DW], e);
            chk($sformatf("rd%0d_busy", j), DW'(rd_busy[j]), DW'(eb));
        end
        chk("ready", DW'(ready), DW'(edges >= D));
        @(posedge clk);
        if (edges >= D) begin
            for (int k = 0; k < NW; k++)
                if (wr_en[k]) begin
                    if (wa[k] != 0) m_regs[wa[k]] = wd[k];
                    m_busy[wa[k]] = 1'b0;
                end
            if (set_en) m_busy[set_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
        edges++;
        @(negedge clk);
    endtask
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", DW'(ready), '0);
        for (int j = 0; j < NR; j++) begin
            chk($sformatf("rst_rd%0d_data", j), rd_data[j*DW +: DW], '0);
            chk($sformatf("rst_rd%0d_busy", j), DW'(rd_busy[j]), '0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < D; i++) m_regs[i] = '0;
        m_busy = '0;
        edges  = 0;
    endtask
    initial begin
        idle();
        for (int k = 0; k < NW; k++) begin wa[k] = '0; wd[k] = '0; end
        for (int j = 0; j < NR; j++) ra[j] = '0;
        set_addr = '0;
        @(negedge clk);
        do_reset();
        // Writes and reservations presented during the clear must be ignored.
        for (int i = 0; i < D; i++) begin
            wr_en = 2'b11; set_en = 1'b1; set_addr = AW'($urandom);
            for (int k = 0; k < NW; k++) begin wa[k] = AW'($urandom); wd[k] = $urandom; end
            ra[0] = AW'(i); ra[1] = AW'($urandom);
            cycle();
        end
        idle();
        for (int i = 0; i < D / 2; i++) begin
            ra[0] = AW'(2 * i); ra[1] = AW'(2 * i + 1);
            cycle();
        end
        wr_en = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[0] = 5; ra[1] = 5;
        cycle();
        idle(); cycle();
        wr_en = 2'b11; wa[0] = 7; wa[1] = 7; wd[0] = 32'h1111; wd[1] = 32'h2222; ra[0] = 7; ra[1] = 7;
        cycle();
        idle(); cycle();
        wr_en = 2'b01; wa[0] = 0; wd[0] = 32'hFFFFFFFF; set_en = 1'b1; set_addr = 0; ra[0] = 0; ra[1] = 0;
        cycle();
        idle(); cycle();
        set_en = 1'b1; set_addr = 9; ra[0] = 9; ra[1] = 9;
        cycle();
        set_en = 1'b1; set_addr = 9; wr_en = 2'b10; wa[1] = 9; wd[1] = 32'h42; wa[0] = 1;
        cycle();
        idle(); cycle();
        wr_en = 2'b01; wa[0] = 3; wd[0] = 32'h55; set_en = 1'b1; set_addr = 4;
        cycle();
        idle(); ra[0] = 3; ra[1] = 4;
        cycle();
        do_reset();
        for (int i = 0; i < D + 2; i++) cycle();
        for (int n = 0; n < 2000; n++) begin
            wr_en  = NW'($urandom);
            set_en = 1'($urandom);
            set_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            for (int k = 0; k < NW; k++) begin
                wa[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                wd[k] = $urandom;
            end
            for (int j = 0; j < NR; j++)
                ra[j] = ($urandom_range(0, 1) == 0) ? wa[$urandom_range(0, NW - 1)] : AW'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
